// File: rtl/dmem_pkg.sv
// Shared types and default configuration for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int          DMEM_DATA_W      = 32;
  localparam int          DMEM_DEPTH       = 64;
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'd1024;
  localparam int          DMEM_WAIT_CYCLES = 0;
  localparam int          DMEM_CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with synchronous byte-enabled write and
// combinational read on a single shared index. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with fixed access latency (IDLE/WAIT/RESP).
// Optional out-of-range error reporting is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DATA_W      = DMEM_DATA_W,
  parameter int          DEPTH       = DMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int          BYTES    = DATA_W / 8;
  localparam int          ADDR_LSB = $clog2(BYTES);
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * BYTES);

  dmem_state_t            state;
  logic [DMEM_CNT_W-1:0]  cnt;

  logic                   cap_write;
  logic [IDX_W-1:0]       cap_idx;
  logic [DATA_W-1:0]      cap_wdata;
  logic [BYTES-1:0]       cap_be;

  logic [31:0]            req_offset;
  logic [IDX_W-1:0]       req_idx;
  logic                   unused_offset_bits;

  logic                   in_idle;
  logic                   accept;
  logic                   enter_resp;
  logic                   acc_write;
  logic [IDX_W-1:0]       acc_idx;
  logic [DATA_W-1:0]      acc_wdata;
  logic [BYTES-1:0]       acc_be;
  logic                   acc_err;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_rdata;

  // Low address bits select a byte within the word and are dropped; high bits wrap.
  assign req_offset         = req_addr - BASE_ADDR;
  assign req_idx            = req_offset[ADDR_LSB +: IDX_W];
  assign unused_offset_bits = ^req_offset;

  // With no wait states the access completes straight from IDLE, so the
  // live request fields are used until the captured copy exists.
  assign in_idle    = (state == IDLE);
  assign accept     = in_idle && req_valid;
  assign acc_write  = in_idle ? req_write : cap_write;
  assign acc_idx    = in_idle ? req_idx   : cap_idx;
  assign acc_wdata  = in_idle ? req_wdata : cap_wdata;
  assign acc_be     = in_idle ? req_be    : cap_be;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == DMEM_CNT_W'(1)));

`ifdef DMEM_RANGE_CHECK_EN
  logic req_err;
  logic cap_err;
  assign req_err = (req_offset >= SPAN);
  assign acc_err = in_idle ? req_err : cap_err;
`else
  assign acc_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign mem_we = enter_resp && acc_write && !acc_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  // Response outputs are loaded on the edge entering RESP and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      rsp_err   <= 1'b0;
      cap_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (acc_write || acc_err) ? '0 : mem_rdata;
`ifdef DMEM_RANGE_CHECK_EN
        rsp_err   <= acc_err;
`endif
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
`ifdef DMEM_RANGE_CHECK_EN
            cap_err   <= req_err;
`endif
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= DMEM_CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - DMEM_CNT_W'(1);
          if (cnt == DMEM_CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: a 32-bit controller with three wait states and a
// 64-bit, 16-word controller with none, both checked against array models.
module tb_data_mem_ctrl;

  localparam int WAITS = 3;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err, busy;

  logic        w_req_valid, w_req_ready, w_req_write;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata, w_rsp_rdata;
  logic [7:0]  w_req_be;
  logic        w_rsp_valid, w_rsp_err, w_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m  [64];
  logic [63:0] mem64_m[16];

  data_mem_ctrl #(
    .DATA_W(32), .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(WAITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_ctrl #(
    .DATA_W(64), .DEPTH(16), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)
  ) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_be(w_req_be),
    .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte address -> word by plain division, wrap by modulo.
  function automatic bit model_oob(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a < 32'd1024) || (a >= 32'd1024 + 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] erd, output logic eerr);
    logic [31:0] off;
    int idx;
    off  = a - 32'd1024;
    idx  = int'((off / 32'd4) % 32'd64);
    eerr = model_oob(a);
    erd  = 32'd0;
    if (!eerr) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        erd = mem_m[idx];
      end
    end
  endtask

  task automatic model64_apply(input logic w, input logic [31:0] a, input logic [63:0] d,
                               input logic [7:0] be, output logic [63:0] erd);
    logic [31:0] off;
    int idx;
    off = a - 32'd1024;
    idx = int'((off / 32'd8) % 32'd16);
    erd = 64'd0;
    if (w) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) mem64_m[idx][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      erd = mem64_m[idx];
    end
  endtask

  // Drives one request, scrambles the inputs after acceptance, waits for the response.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) begin
      total++; bad++;
      $display("[TB] FAIL access_timeout: addr=%h no rsp_valid within 50 cycles", a);
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic access64(input logic w, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] be, output logic [63:0] rd, output int lat);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_write = w; w_req_addr = a; w_req_wdata = d; w_req_be = be;
    @(posedge clk);
    @(negedge clk);
    w_req_valid = 1'b0; w_req_addr = $urandom; w_req_wdata = {$urandom, $urandom};
    w_req_be = 8'($urandom);
    lat = 1;
    while (w_rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) begin
      total++; bad++;
      $display("[TB] FAIL access64_timeout: addr=%h no rsp_valid within 50 cycles", a);
    end
    rd = w_rsp_rdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (w_req_ready !== 1'b1 || w_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_wide_ready_busy: got %b%b want 10", w_req_ready, w_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init;
    logic [31:0] rd, erd, d;
    logic er, eerr;
    int lat;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      access(1'b1, 32'd1024 + 32'(i * 4), d, 4'hF, rd, er, lat);
      model_apply(1'b1, 32'd1024 + 32'(i * 4), d, 4'hF, erd, eerr);
      total++; if (rd !== erd || er !== eerr) begin bad++; $display("[TB] FAIL init_write[%0d]: got rd=%h err=%b want rd=%h err=%b", i, rd, er, erd, eerr); end
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd, erd;
    logic er, eerr;
    int lat;
    access(1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, rd, er, lat);
    model_apply(1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, erd, eerr);
    access(1'b0, 32'd1024, 32'd0, 4'h0, rd, er, lat);
    model_apply(1'b0, 32'd1024, 32'd0, 4'h0, erd, eerr);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL basic_read: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL basic_err: got %b want 0", er); end
    total++; if (lat != WAITS + 1) begin bad++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, WAITS + 1); end
  endtask

  task automatic test_timing;
    logic exp_v;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024; req_be = 4'h0;
    @(posedge clk);
    for (int k = 1; k <= WAITS + 2; k++) begin
      @(negedge clk);
      exp_v = (k == WAITS + 1);
      total++; if (rsp_valid !== exp_v) begin bad++; $display("[TB] FAIL timing_rsp_valid[N+%0d]: got %b want %b", k, rsp_valid, exp_v); end
      if (k <= WAITS + 1) begin
        total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("[TB] FAIL timing_busy_ready[N+%0d]: got %b%b want 10", k, busy, req_ready); end
      end else begin
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("[TB] FAIL timing_idle[N+%0d]: got %b%b want 01", k, busy, req_ready); end
      end
      if (exp_v) begin
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL timing_rdata: got %h want deadbeef", rsp_rdata); end
      end
      if (k == 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd, erd;
    logic er, eerr;
    int lat;
    access(1'b1, 32'd1028, 32'h11223344, 4'hF, rd, er, lat);
    model_apply(1'b1, 32'd1028, 32'h11223344, 4'hF, erd, eerr);
    access(1'b1, 32'd1028, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    model_apply(1'b1, 32'd1028, 32'hAABBCCDD, 4'b0101, erd, eerr);
    total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL be_write_rdata: got %h want 0", rd); end
    access(1'b0, 32'd1029, 32'd0, 4'h0, rd, er, lat);
    model_apply(1'b0, 32'd1029, 32'd0, 4'h0, erd, eerr);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL be_merge: got %h want 11bb33dd", rd); end
    access(1'b1, 32'd1028, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    access(1'b0, 32'd1028, 32'd0, 4'h0, rd, er, lat);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL be_zero_write: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_rdata_hold;
    logic [31:0] rd;
    logic er;
    int lat;
    access(1'b0, 32'd1028, 32'd0, 4'h0, rd, er, lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (rsp_rdata !== 32'h11BB33DD || rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rdata_hold[%0d]: got %h v=%b want 11bb33dd v=0", k, rsp_rdata, rsp_valid); end
    end
  endtask

  task automatic test_range;
    logic [31:0] rd, erd, d;
    logic er, eerr;
    int lat;
    d = $urandom;
    access(1'b1, 32'd1280, d, 4'hF, rd, er, lat);
    model_apply(1'b1, 32'd1280, d, 4'hF, erd, eerr);
    total++; if (er !== eerr || rd !== erd) begin bad++; $display("[TB] FAIL range_high_write: got err=%b rd=%h want err=%b rd=%h", er, rd, eerr, erd); end
    access(1'b0, 32'd1024, 32'd0, 4'h0, rd, er, lat);
    model_apply(1'b0, 32'd1024, 32'd0, 4'h0, erd, eerr);
    total++; if (rd !== erd || er !== 1'b0) begin bad++; $display("[TB] FAIL range_word0: got %h want %h", rd, erd); end
    access(1'b0, 32'd1020, 32'd0, 4'h0, rd, er, lat);
    model_apply(1'b0, 32'd1020, 32'd0, 4'h0, erd, eerr);
    total++; if (er !== eerr || rd !== erd) begin bad++; $display("[TB] FAIL range_below_base: got err=%b rd=%h want err=%b rd=%h", er, rd, eerr, erd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a, d;
    logic [3:0] be;
    logic er, eerr, w;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      be  = 4'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      a = 32'd1280 + 32'($urandom_range(0, 255));
      else if (sel == 1) a = 32'd1024 - 32'($urandom_range(1, 64));
      else               a = 32'd1024 + 32'($urandom_range(0, 255));
      access(w, a, d, be, rd, er, lat);
      model_apply(w, a, d, be, erd, eerr);
      total++; if (rd !== erd || er !== eerr || lat != WAITS + 1) begin bad++; $display("[TB] FAIL random[%0d] w=%b a=%h: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", i, w, a, rd, er, lat, erd, eerr, WAITS + 1); end
    end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    logic [31:0] exp_d;
    exp_d = mem_m[0];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024; req_be = 4'h0;
    for (int c = 1; c <= 3 * (WAITS + 2) - 1; c++) begin
      @(negedge clk);
      exp_v = ((c % (WAITS + 2)) == WAITS + 1);
      total++; if (rsp_valid !== exp_v) begin bad++; $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        total++; if (rsp_rdata !== exp_d) begin bad++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", c, rsp_rdata, exp_d); end
      end
      if (c == WAITS + 2) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_gap: got %b want 1", req_ready); end
      end
      if (c == 3 * (WAITS + 2) - 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, old;
    logic er;
    int lat;
    old = mem_m[2];
    access(1'b0, 32'd1032, 32'd0, 4'h0, rd, er, lat);
    total++; if (rd !== old) begin bad++; $display("[TB] FAIL abort_pre_read: got %h want %h", rd, old); end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1032; req_wdata = ~old; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_wait: got busy=%b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_reset_outputs: got v=%b d=%h e=%b busy=%b rdy=%b want 0 0 0 0 1", rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'd1032, 32'd0, 4'h0, rd, er, lat);
    total++; if (rd !== old) begin bad++; $display("[TB] FAIL abort_write_dropped: got %h want %h", rd, old); end
  endtask

  task automatic test_wide;
    logic [63:0] rd, erd, d;
    int lat;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      access64(1'b1, 32'd1024 + 32'(i * 8), d, 8'hFF, rd, lat);
      model64_apply(1'b1, 32'd1024 + 32'(i * 8), d, 8'hFF, erd);
    end
    d = {$urandom, $urandom};
    access64(1'b1, 32'd1032, d, 8'hFF, rd, lat);
    model64_apply(1'b1, 32'd1032, d, 8'hFF, erd);
    total++; if (rd !== 64'd0 || lat != 1) begin bad++; $display("[TB] FAIL wide_write: got rd=%h lat=%0d want 0 lat=1", rd, lat); end
    access64(1'b0, 32'd1036, 64'd0, 8'h0, rd, lat);
    total++; if (rd !== d) begin bad++; $display("[TB] FAIL wide_alias: got %h want %h", rd, d); end
    access64(1'b0, 32'd1024, 64'd0, 8'h0, rd, lat);
    model64_apply(1'b0, 32'd1024, 64'd0, 8'h0, erd);
    total++; if (rd !== erd) begin bad++; $display("[TB] FAIL wide_word0: got %h want %h", rd, erd); end
    d = {$urandom, $urandom};
    access64(1'b1, 32'd1036, d, 8'h0F, rd, lat);
    model64_apply(1'b1, 32'd1036, d, 8'h0F, erd);
    access64(1'b0, 32'd1032, 64'd0, 8'h0, rd, lat);
    model64_apply(1'b0, 32'd1032, 64'd0, 8'h0, erd);
    total++; if (rd !== erd || w_rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL wide_partial: got %h err=%b want %h err=0", rd, w_rsp_err, erd); end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0;
    w_req_valid = 1'b0; w_req_write = 1'b0; w_req_addr = 32'd0; w_req_wdata = 64'd0; w_req_be = 8'h0;
    test_reset;
    test_init;
    test_basic;
    test_timing;
    test_byte_enable;
    test_rdata_hold;
    test_range;
    test_random;
    test_back_to_back;
    test_reset_abort;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 64: number of words, a power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 32'd1024: byte address of word 0.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: extra access cycles; legal range 0..15.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1 bit: request present.
REQ-009 SHALL have port req_ready, output, 1 bit: request accepted when high with req_valid.
REQ-010 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, 32 bits: byte address.
REQ-012 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-013 SHALL have port req_be, input, DATA_W/8 bits: byte write enables.
REQ-014 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-016 SHALL have port rsp_err, output, 1 bit: out-of-range access, qualified by rsp_valid.
REQ-017 SHALL have port busy, output, 1 bit: high while an access is in flight, used as the pipeline stall.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance, SHALL capture write, address, wdata and be; later changes to the inputs SHALL be ignored.
REQ-020 SHALL compute word index as (addr - BASE_ADDR) >> log2(DATA_W/8), using 32-bit unsigned subtraction; the low address bits SHALL be ignored (no alignment fault).
REQ-021 On acceptance, SHALL go IDLE->RESP if WAIT_CYCLES==0, else IDLE->WAIT.
REQ-022 In WAIT, SHALL count down from WAIT_CYCLES and go WAIT->RESP after WAIT_CYCLES cycles.
REQ-023 SHALL go RESP->IDLE unconditionally.
REQ-024 SHALL assert rsp_valid for exactly one cycle (in RESP), WAIT_CYCLES+1 cycles after acceptance; there is no response backpressure.
REQ-025 SHALL commit a write on the clock edge entering RESP, updating only the bytes whose req_be bit is 1; a write with be all zero SHALL change nothing.
REQ-026 For a read, rsp_rdata SHALL show the addressed word during RESP; for a write, rsp_rdata SHALL be 0.
REQ-027 rsp_rdata SHALL hold its value until the next RESP.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 Back-to-back requests SHALL be accepted no sooner than the cycle after RESP, giving a throughput of one access per WAIT_CYCLES+2 cycles.

Reset
REQ-030 While rst_n is low: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 1.
REQ-031 Reset asserted mid-access SHALL abort the access; an uncommitted write SHALL be dropped.
REQ-032 Memory array contents SHALL NOT be reset.

Configuration
REQ-033 Macro DMEM_RANGE_CHECK_EN defined: an address below BASE_ADDR or at/above BASE_ADDR + DEPTH*(DATA_W/8) SHALL give rsp_err = 1 in RESP, suppress the write, and return rsp_rdata = 0.
REQ-034 Macro DMEM_RANGE_CHECK_EN undefined: the index SHALL wrap modulo DEPTH and rsp_err SHALL be constant 0.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and default-parameter constants.
REQ-036 A sub-module dmem_array SHALL hold the storage, with synchronous byte-enabled write and combinational read.

Verification
REQ-037 Reset, then read 1024 after writing 0xDEADBEEF with be=4'hF -> rsp_rdata=0xDEADBEEF.
REQ-038 With WAIT_CYCLES=3, accept a read at cycle N -> rsp_valid only at N+4; req_ready=0 and busy=1 for N+1..N+4.
REQ-039 Write 0xAABBCCDD with be=4'b0101 over 0x11223344 at 1028 -> read gives 0x11BB33DD.
REQ-040 With DMEM_RANGE_CHECK_EN, write to 1024+256 -> rsp_err=1, word 0 unchanged; with the macro undefined, the same access wraps and writes word 0.
REQ-041 Deassert rst_n during WAIT of a write to 1032 -> outputs go to reset values immediately; a following read of 1032 returns the old data.
REQ-042 With DATA_W=64 and DEPTH=16, write at 1024+8 -> word 1 updated; address 1024+12 aliases word 1.
